// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit beside the EX stage: shift-add multiply, restoring divide.
// Optional build macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish straight from IDLE.
module ex_muldiv #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 4
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            start_in,
  input  logic [2:0]      op_in,
  input  logic [XLEN-1:0] rs1_val_in,
  input  logic [XLEN-1:0] rs2_val_in,
  input  logic [4:0]      rd_addr_in,
  input  logic            flush_in,
  output logic            busy_out,
  output logic            stallreq_out,
  output logic            done_out,
  output logic            rd_out,
  output logic [4:0]      rd_addr_out,
  output logic [XLEN-1:0] rd_val_out
);
  localparam int N_MUL = XLEN / MUL_STEP;
  localparam int CW    = $clog2(XLEN + 1);

  generate
    if (!(MUL_STEP == 1 || MUL_STEP == 2 || MUL_STEP == 4 || MUL_STEP == 8 || MUL_STEP == XLEN)
        || (XLEN % MUL_STEP) != 0) begin : g_bad_mul_step
      $error("ex_muldiv: MUL_STEP must be 1, 2, 4, 8 or XLEN and divide XLEN");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t state;

  logic [2:0]        op_q;
  logic [4:0]        rd_addr_q;
  logic              neg_q;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] prod_q;   // MUL: {partial hi, multiplier}; DIV: {remainder, dividend/quotient}
  logic [XLEN-1:0]   opb_q;    // MUL: multiplicand; DIV: divisor

  // Handshake: start_in is the valid; the unit is ready only in IDLE with no flush.
  // stallreq_out holds the producer (and its operands) until the result is presented in DONE.
  assign stallreq_out = (start_in && state == S_IDLE && !flush_in) || state == S_MUL || state == S_DIV;

  logic            a_signed, b_signed, a_neg, b_neg, div_zero, neg_start;
  logic [XLEN-1:0] a_abs, b_abs;

  always_comb begin
    a_signed  = op_in[2] ? !op_in[0] : (op_in[1:0] == 2'b01 || op_in[1:0] == 2'b10);
    b_signed  = op_in[2] ? !op_in[0] : (op_in[1:0] == 2'b01);
    a_neg     = a_signed && rs1_val_in[XLEN-1];
    b_neg     = b_signed && rs2_val_in[XLEN-1];
    a_abs     = a_neg ? -rs1_val_in : rs1_val_in;
    b_abs     = b_neg ? -rs2_val_in : rs2_val_in;
    div_zero  = (rs2_val_in == '0);
    // A zero divisor must leave the all-ones quotient unnegated; the remainder follows the dividend.
    if (!op_in[2])     neg_start = a_neg ^ b_neg;
    else if (op_in[1]) neg_start = a_neg;
    else               neg_start = (a_neg ^ b_neg) && !div_zero;
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic            div_ovf;
  logic [XLEN-1:0] early_val;
  always_comb begin
    div_ovf   = !op_in[0] && rs1_val_in == {1'b1, {(XLEN-1){1'b0}}} && rs2_val_in == '1;
    early_val = '0;
    if (op_in[1]) early_val = div_zero ? rs1_val_in : '0;
    else          early_val = div_zero ? '1 : rs1_val_in;
  end
`endif

  // One multiply step: add multiplicand times the low MUL_STEP multiplier bits, then shift right.
  logic [XLEN+MUL_STEP-1:0] ext_hi, ext_b, ext_d, mul_sum;
  logic [2*XLEN-1:0]        mul_next, mul_full;
  logic [XLEN-1:0]          mul_res;

  always_comb begin
    ext_hi   = {{MUL_STEP{1'b0}}, prod_q[2*XLEN-1:XLEN]};
    ext_b    = {{MUL_STEP{1'b0}}, opb_q};
    ext_d    = {{XLEN{1'b0}}, prod_q[MUL_STEP-1:0]};
    mul_sum  = ext_hi + ext_b * ext_d;
    mul_next = (2*XLEN)'({mul_sum, prod_q[XLEN-1:0]} >> MUL_STEP);
    mul_full = neg_q ? -mul_next : mul_next;
    mul_res  = (op_q[1:0] == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
  end

  // One restoring-division step: shift in the next dividend bit and subtract if it fits.
  logic [XLEN:0]     div_sh;
  logic [XLEN-1:0]   div_diff, rem_next, div_sel, div_res;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    div_sh   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    div_ge   = div_sh >= {1'b0, opb_q};
    div_diff = XLEN'(div_sh - {1'b0, opb_q});
    rem_next = div_ge ? div_diff : div_sh[XLEN-1:0];
    div_next = {rem_next, prod_q[XLEN-2:0], div_ge};
    div_sel  = op_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
    div_res  = neg_q ? -div_sel : div_sel;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= S_IDLE;
      busy_out    <= 1'b0;
      done_out    <= 1'b0;
      rd_out      <= 1'b0;
      rd_addr_out <= '0;
      rd_val_out  <= '0;
      op_q        <= '0;
      rd_addr_q   <= '0;
      neg_q       <= 1'b0;
      cnt         <= '0;
      prod_q      <= '0;
      opb_q       <= '0;
    end else if (flush_in) begin
      state    <= S_IDLE;
      busy_out <= 1'b0;
      done_out <= 1'b0;
      rd_out   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_out <= 1'b0;
          rd_out   <= 1'b0;
          if (start_in) begin
            op_q      <= op_in;
            rd_addr_q <= rd_addr_in;
            neg_q     <= neg_start;
            cnt       <= '0;
            busy_out  <= 1'b1;
            if (op_in[2]) begin
              prod_q <= {{XLEN{1'b0}}, a_abs};
              opb_q  <= b_abs;
            end else begin
              prod_q <= {{XLEN{1'b0}}, b_abs};
              opb_q  <= a_abs;
            end
`ifdef MULDIV_EARLY_OUT_EN
            if (op_in[2] && (div_zero || div_ovf)) begin
              state       <= S_DONE;
              done_out    <= 1'b1;
              rd_out      <= (rd_addr_in != 5'd0);
              rd_addr_out <= rd_addr_in;
              rd_val_out  <= early_val;
            end else
`endif
            state <= op_in[2] ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          prod_q <= mul_next;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(N_MUL - 1)) begin
            state       <= S_DONE;
            done_out    <= 1'b1;
            rd_out      <= (rd_addr_q != 5'd0);
            rd_addr_out <= rd_addr_q;
            rd_val_out  <= mul_res;
          end
        end
        S_DIV: begin
          prod_q <= div_next;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(XLEN - 1)) begin
            state       <= S_DONE;
            done_out    <= 1'b1;
            rd_out      <= (rd_addr_q != 5'd0);
            rd_addr_out <= rd_addr_q;
            rd_val_out  <= div_res;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          busy_out <= 1'b0;
          done_out <= 1'b0;
          rd_out   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv (XLEN=32, MUL_STEP=4): vector table, scoreboard queue, corner sequences.
module tb_ex_muldiv;
  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        start_in;
  logic [2:0]  op_in;
  logic [31:0] rs1_val_in, rs2_val_in;
  logic [4:0]  rd_addr_in;
  logic        flush_in;
  logic        busy_out, stallreq_out, done_out, rd_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_val_out;

  ex_muldiv #(.XLEN(32), .MUL_STEP(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .op_in(op_in),
    .rs1_val_in(rs1_val_in), .rs2_val_in(rs2_val_in), .rd_addr_in(rd_addr_in),
    .flush_in(flush_in), .busy_out(busy_out), .stallreq_out(stallreq_out),
    .done_out(done_out), .rd_out(rd_out), .rd_addr_out(rd_addr_out), .rd_val_out(rd_val_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 33;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [4:0]  addr_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic        ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // driver: called at a falling edge with the unit idle; cycle 0 is the current cycle
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] ev);
    start_in = 1'b1; op_in = op; rs1_val_in = a; rs2_val_in = b; rd_addr_in = rd;
    exp_q.push_back(ev);
    addr_q.push_back(rd);
    #1 check("stall_at_accept", {31'b0, stallreq_out}, 32'd1);
    @(posedge clk_in); #1 start_in = 1'b0;
  endtask

  // waits for done_out (bounded), checks latency, stall profile and the scoreboard head
  task automatic wait_done(input int exp_lat, input string name);
    int cyc, stall_bad;
    logic [31:0] ev;
    logic [4:0]  ea;
    cyc = 0; stall_bad = 0;
    do begin
      @(negedge clk_in);
      cyc++;
      if (!done_out && stallreq_out !== 1'b1) stall_bad++;
    end while (!done_out && cyc < 60);
    if (stallreq_out !== 1'b0) stall_bad++;
    check({name, "_latency"}, cyc, exp_lat);
    check({name, "_stall"}, stall_bad, 0);
    if (exp_q.size() == 0) begin
      check({name, "_scoreboard_empty"}, 1, 0);
    end else begin
      ev = exp_q.pop_front();
      ea = addr_q.pop_front();
      check({name, "_val"}, rd_val_out, ev);
      check({name, "_addr"}, {27'b0, rd_addr_out}, {27'b0, ea});
      check({name, "_rd"}, {31'b0, rd_out}, {31'b0, (ea != 5'd0)});
    end
  endtask

  task automatic expect_idle(input string name);
    @(negedge clk_in);
    check({name, "_idle_busy"}, {31'b0, busy_out}, 0);
    check({name, "_idle_done"}, {31'b0, done_out}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [4:0]  rrd;
    rst_n_in = 1'b0; start_in = 1'b0; op_in = '0; rs1_val_in = '0; rs2_val_in = '0;
    rd_addr_in = '0; flush_in = 1'b0;
    #1;
    check("reset_busy", {31'b0, busy_out}, 0);
    check("reset_done", {31'b0, done_out}, 0);
    check("reset_rd", {31'b0, rd_out}, 0);
    check("reset_addr", {27'b0, rd_addr_out}, 0);
    check("reset_val", rd_val_out, 0);
    check("reset_stall", {31'b0, stallreq_out}, 0);
    #20;
    @(negedge clk_in) rst_n_in = 1'b1;
    @(negedge clk_in);

    // vector table: {op, rs1, rs2, rd, expected value, expected done cycle}
    vecs.push_back('{3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 9});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 9});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 9});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'hFFFF_FFFF, 9});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD, 33});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd5, 32'd100,       32'd7,         5'd0,  32'd14,        33});
    vecs.push_back('{3'd5, 32'd5,         32'd0,         5'd7,  32'hFFFF_FFFF, EO_LAT});
    vecs.push_back('{3'd7, 32'd5,         32'd0,         5'd8,  32'd5,         EO_LAT});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000, EO_LAT});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000, EO_LAT});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd0,         5'd11, 32'hFFFF_FFFF, EO_LAT});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd0,         5'd12, 32'hFFFF_FFF9, EO_LAT});
    vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd13, 32'h4000_0000, 9});
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      rrd = 5'($urandom_range(0, 31));
      vecs.push_back('{rop, ra, rb, rrd, model(rop, ra, rb),
        !rop[2] ? 9 : ((rb == 0 || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? EO_LAT : 33)});
    end
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);
      wait_done(vecs[i].lat, $sformatf("vec%0d", i));
      expect_idle($sformatf("vec%0d", i));
    end

    // start held high through DONE: the DONE-cycle start is ignored, the next idle cycle accepts
    start_in = 1'b1; op_in = 3'd0; rs1_val_in = 32'd3; rs2_val_in = 32'd5; rd_addr_in = 5'd14;
    exp_q.push_back(32'd15); addr_q.push_back(5'd14);
    @(posedge clk_in);
    wait_done(9, "hold1");
    exp_q.push_back(32'd15); addr_q.push_back(5'd14);
    @(negedge clk_in);
    check("hold_idle_stall", {31'b0, stallreq_out}, 1);
    @(posedge clk_in); #1 start_in = 1'b0;
    wait_done(9, "hold2");
    expect_idle("hold2");

    // flush in cycle 5 of a DIV, then a start in cycle 6
    start_in = 1'b1; op_in = 3'd5; rs1_val_in = 32'd1000; rs2_val_in = 32'd3; rd_addr_in = 5'd15;
    @(posedge clk_in); #1 start_in = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_in);
      if (done_out) ndone++;
    end
    flush_in = 1'b1;
    @(posedge clk_in); #1 flush_in = 1'b0;
    @(negedge clk_in);
    check("flush_busy_c6", {31'b0, busy_out}, 0);
    check("flush_done_c6", {31'b0, done_out}, 0);
    check("flush_no_done_before", ndone, 0);
    issue(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd16, 32'hFFFF_FFF2);
    wait_done(33, "after_flush");
    expect_idle("after_flush");

    // flush together with start in IDLE: not accepted
    start_in = 1'b1; flush_in = 1'b1; op_in = 3'd0; rs1_val_in = 32'd9; rs2_val_in = 32'd9; rd_addr_in = 5'd17;
    #1 check("flush_start_stall", {31'b0, stallreq_out}, 0);
    @(posedge clk_in); #1 begin start_in = 1'b0; flush_in = 1'b0; end
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_in);
      if (done_out || busy_out) ndone++;
    end
    check("flush_start_ignored", ndone, 0);

    // asynchronous reset in the middle of a MUL
    issue(3'd0, 32'd6, 32'd7, 5'd18, 32'd42);
    wait_done(9, "pre_reset");
    expect_idle("pre_reset");
    start_in = 1'b1; op_in = 3'd0; rs1_val_in = 32'd11; rs2_val_in = 32'd13; rd_addr_in = 5'd19;
    @(posedge clk_in); #1 start_in = 1'b0;
    repeat (3) @(negedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy_out}, 0);
    check("arst_stall", {31'b0, stallreq_out}, 0);
    check("arst_done", {31'b0, done_out}, 0);
    check("arst_rd", {31'b0, rd_out}, 0);
    check("arst_addr", {27'b0, rd_addr_out}, 0);
    check("arst_val", rd_val_out, 0);
    @(negedge clk_in) rst_n_in = 1'b1;
    expect_idle("post_reset");
    issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd20, model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678));
    wait_done(9, "post_reset_op");
    expect_idle("post_reset_op");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide execution unit that sits beside the combinational EX stage and handles MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. The datapath width and the number of multiplier bits retired per cycle are parameters. The unit accepts one operation, holds the pipeline through `stallreq_out` while it iterates, and then presents the result with write-back information for one cycle. It supports a pipeline flush in every state.

## Interface
- `XLEN`, default 32: operand and result width.
- `MUL_STEP`, default 4: multiplier bits retired per cycle. Legal values are 1, 2, 4, 8 or `XLEN`, and `XLEN % MUL_STEP` must be 0; elaboration fails otherwise.
- `clk_in`  input  1: the single clock. All state changes on its rising edge.
- `rst_n_in`  input  1: reset, asynchronous and active-low.
- `start_in`  input  1: request to start an operation.
- `op_in`  input  3: RV32M funct3. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_val_in`  input  XLEN: dividend / multiplicand.
- `rs2_val_in`  input  XLEN: divisor / multiplier.
- `rd_addr_in`  input  5: destination register.
- `flush_in`  input  1: abandon the current operation.
- `busy_out`  output  1: high while state is not IDLE.
- `stallreq_out`  output  1: stall request to the pipeline controller.
- `done_out`  output  1: one-cycle result-valid pulse.
- `rd_out`  output  1: register-write enable, qualified by `done_out`.
- `rd_addr_out`  output  5: destination register of the result.
- `rd_val_out`  output  XLEN: result value.

## Operation
- **States:** IDLE, MUL, DIV, DONE.
- **IDLE:**
  - When `start_in`=1 and `flush_in`=0, latch `op_in`, `rd_addr_in`, absolute-value operands and the result sign.
  - op[2]=0 goes to MUL; op[2]=1 goes to DIV.
- **MUL:**
  - Shift-add `MUL_STEP` multiplier bits per cycle into a 2·`XLEN` accumulator.
  - The state lasts N_MUL = `XLEN`/`MUL_STEP` cycles, then goes to DONE.
- **DIV:**
  - Restoring division, one quotient bit per cycle.
  - The state lasts N_DIV = `XLEN` cycles, then goes to DONE.
- **DONE:**
  - The registered outputs are valid for this one cycle, then the unit returns to IDLE.
  - `start_in` in DONE is ignored; a new operation can start in the following cycle.
- **Result selection:**
  - MUL returns the low `XLEN` bits.
  - MULH returns the high half of signed×signed, MULHSU of signed×unsigned, MULHU of unsigned×unsigned.
  - The sign of the product is applied to the full 2·`XLEN` value before the half is selected.
- **Division rules:**
  - Signed quotients truncate toward zero; the remainder takes the sign of the dividend.
  - Divide by zero: quotient = all ones, remainder = dividend (DIV/DIVU and REM/REMU alike).
  - Signed overflow (dividend = -2^(`XLEN`-1), divisor = -1): quotient = dividend, remainder = 0.
- **Write-back:** `rd_out` = 1 in DONE only when `rd_addr` != 0.
- **`start_in` while busy:** ignored. The producer must hold the instruction, which it does because of `stallreq_out`.
- **Flush:**
  - `flush_in`=1 in any state forces IDLE at the next edge, with no `done_out`.
  - Flush together with `start_in` in IDLE: the start is not accepted.

## Timing
- **Reset:** while `rst_n_in`=0, and immediately on its assertion even mid-operation:
  - state = IDLE;
  - `busy_out`, `stallreq_out`, `done_out` and `rd_out` = 0;
  - `rd_addr_out` = 0 and `rd_val_out` = 0.
- **Latency:** with `start_in` accepted in cycle 0:
  - compute cycles are 1..N;
  - `done_out`=1 in cycle N+1, so MUL completes in cycle N_MUL+1 and DIV in cycle `XLEN`+1.
- **`stallreq_out`:**
  - Combinational: `start_in`&&IDLE&&!`flush_in`, OR state is MUL or DIV.
  - Low in DONE, so the stalled instruction advances in the same cycle the result is presented.
- **`busy_out`:** registered; high in cycles 1..N+1.
- **Output hold:** `rd_val_out` and `rd_addr_out` keep their last value outside DONE. `done_out` and `rd_out` are 0 outside DONE.

## Configuration
- **`MULDIV_EARLY_OUT_EN`:**
  - Defined: a DIV-class operation whose divisor is zero, or which hits signed overflow, goes from IDLE straight to DONE, so `done_out` rises in cycle 1.
  - Undefined: these cases take the full `XLEN` iterations. The final result correction still produces the values above, and `done_out` rises in cycle `XLEN`+1.
  - Multiply timing is identical in both builds.

## Test plan
All scenarios use `XLEN`=32 and `MUL_STEP`=4.
- MUL 7 × 0xFFFFFFFD, rd=5 → `done_out` only in cycle 9; `rd_val_out`=0xFFFFFFEB, `rd_out`=1, `rd_addr_out`=5; `stallreq_out` high in cycles 0–8.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH with the same operands → 0x00000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD in cycle 33. REM with the same operands → 0xFFFFFFFF. DIVU 100 / 7, rd=0 → 14 with `rd_out`=0.
- DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5. `done_out` in cycle 1 with `MULDIV_EARLY_OUT_EN`, cycle 33 without.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Flush and reset:
  - Assert `flush_in` in cycle 5 of a DIV → no `done_out`, `busy_out`=0 in cycle 6, and a start in cycle 6 completes normally.
  - Drop `rst_n_in` mid-MUL → all outputs 0 with no clock edge; the unit is in IDLE after release.
